mtx_ser: RTL and testbench

//  MIO transmit serializer: the transmit-side counterpart of the mrx_io receive path.
//  - Accepts one PW-bit packet from the core side (transmit FIFO output).
//  - Sends it LSB-first as fixed-width beats on the MIO pins, with tx_access framing and tx_wait pushback.
//  - Sits between the transmit FIFO and the IO cells. Single clock domain; DDR is done in the IO cells.

---
 rtl/mtx_ser_pkg.sv | 19 +
 rtl/mtx_ser.sv | 136 +++++++++++++
 tb/tb_mtx_ser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mtx_ser_pkg.sv
// Shared MIO transmit definitions: lane-width encodings, FSM states and sizing helpers.
package mtx_ser_pkg;

    localparam logic [1:0] MIO_W8  = 2'd0;
    localparam logic [1:0] MIO_W16 = 2'd1;
    localparam logic [1:0] MIO_W32 = 2'd2;
    localparam logic [1:0] MIO_W64 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } mtx_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mtx_ser.sv
// MIO transmit serializer: sends one PW-bit packet LSB-first as W-bit beats framed by
// tx_access, honours tx_wait pushback and leaves a one-cycle gap between packets.
module mtx_ser
    import mtx_ser_pkg::*;
#(
    parameter int unsigned PW  = 104,
    parameter int unsigned IOW = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [1:0]     iowidth,
    input  logic           access_in,
    input  logic [PW-1:0]  packet_in,
    output logic           wait_out,
    output logic           tx_access,
    output logic [IOW-1:0] tx_packet,
    input  logic           tx_wait
);

    localparam int unsigned SRW  = (PW > IOW) ? PW : IOW;
    localparam int unsigned NB8  = ceil_div(PW, 8);
    localparam int unsigned NB16 = ceil_div(PW, 16);
    localparam int unsigned NB32 = ceil_div(PW, 32);
    localparam int unsigned NB64 = ceil_div(PW, 64);
    localparam int unsigned CW   = (NB8 > 1) ? $clog2(NB8) : 1;
    localparam logic [1:0]  WMAX = (IOW >= 64) ? MIO_W64 :
                                   (IOW >= 32) ? MIO_W32 :
                                   (IOW >= 16) ? MIO_W16 : MIO_W8;

    mtx_state_e     state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [1:0]     wsel_q, wsel_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IOW-1:0] tx_packet_q, tx_packet_d;
    logic           send_q;

    logic [1:0]     wsel_in;
    logic [SRW-1:0] sr_load;
    logic [SRW-1:0] sr_shift;

    function automatic logic [CW-1:0] last_beat(input logic [1:0] code);
        case (code)
            MIO_W8:  return CW'(NB8 - 1);
            MIO_W16: return CW'(NB16 - 1);
            MIO_W32: return CW'(NB32 - 1);
            default: return CW'(NB64 - 1);
        endcase
    endfunction

    // Low W bits of the shift register; lanes above W are forced to zero.
    function automatic logic [IOW-1:0] beat_of(input logic [SRW-1:0] sr, input logic [1:0] code);
        logic [IOW-1:0] m;
        for (int i = 0; i < int'(IOW); i++) begin
            m[i] = (i < (8 << int'(code)));
        end
        return sr[IOW-1:0] & m;
    endfunction

    function automatic logic [SRW-1:0] shift_beat(input logic [SRW-1:0] sr, input logic [1:0] code);
        case (code)
            MIO_W8:  return sr >> 8;
            MIO_W16: return sr >> 16;
            MIO_W32: return sr >> 32;
            default: return sr >> 64;
        endcase
    endfunction

    assign wsel_in  = (iowidth > WMAX) ? WMAX : iowidth;
    assign sr_load  = SRW'(packet_in);
    assign sr_shift = shift_beat(sr_q, wsel_q);

    // Next-state and datapath: load on accept, shift on each transferred beat.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        wsel_d      = wsel_q;
        cnt_d       = cnt_q;
        tx_packet_d = tx_packet_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (access_in) begin
                    state_d     = ST_SEND;
                    wsel_d      = wsel_in;
                    sr_d        = sr_load;
                    cnt_d       = last_beat(wsel_in);
                    tx_packet_d = beat_of(sr_load, wsel_in);
                end else begin
                    state_d     = ST_IDLE;
                    tx_packet_d = '0;
                end
            end
            ST_SEND: begin
                if (!tx_wait) begin
                    if (cnt_q == '0) begin
                        state_d     = ST_GAP;
                        sr_d        = '0;
                        tx_packet_d = '0;
                    end else begin
                        sr_d        = sr_shift;
                        cnt_d       = cnt_q - CW'(1);
                        tx_packet_d = beat_of(sr_shift, wsel_q);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tx_packet_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            wsel_q      <= MIO_W8;
            cnt_q       <= '0;
            tx_packet_q <= '0;
            send_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            wsel_q      <= wsel_d;
            cnt_q       <= cnt_d;
            tx_packet_q <= tx_packet_d;
            send_q      <= (state_d == ST_SEND);
        end
    end

    // Frame valid and FIFO pushback are both the registered SEND decode.
    assign tx_access = send_q;
    assign wait_out  = send_q;
    assign tx_packet = tx_packet_q;

endmodule

// File: tb/tb_mtx_ser.sv
// Directed bench for mtx_ser: expected beats are queued at stimulus time and
// checked by a negedge monitor as the serializer emits them.
module tb_mtx_ser;

    localparam int unsigned PW  = 104;
    localparam int unsigned IOW = 64;

    logic           clk;
    logic           nreset;
    logic [1:0]     iowidth;
    logic           access_in;
    logic [PW-1:0]  packet_in;
    logic           wait_out;
    logic           tx_access;
    logic [IOW-1:0] tx_packet;
    logic           tx_wait;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mtx_ser #(.PW(PW), .IOW(IOW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .iowidth   (iowidth),
        .access_in (access_in),
        .packet_in (packet_in),
        .wait_out  (wait_out),
        .tx_access (tx_access),
        .tx_packet (tx_packet),
        .tx_wait   (tx_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] make_pkt(input logic [7:0] base);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) p[8*i +: 8] = base + 8'(i);
        return p;
    endfunction

    // Byte-oriented reference: beat k of width 8<<code carries bytes k*wb .. k*wb+wb-1.
    task automatic push_beats(input logic [7:0] base, input int code);
        int wb;
        int nb;
        logic [63:0] beat;
        wb = 1 << code;
        nb = (13 + wb - 1) / wb;
        for (int k = 0; k < nb; k++) begin
            beat = '0;
            for (int b = 0; b < wb; b++) begin
                if (k * wb + b < 13) beat[8*b +: 8] = base + 8'(k * wb + b);
            end
            exp_q.push_back(beat);
        end
    endtask

    // Data monitor: check held beat under tx_wait, pop on transfer, idle bus must be zero.
    always @(negedge clk) begin
        if (tx_access) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", tx_packet, 64'h0);
                chk("unexpected_beat_valid", {63'h0, tx_access}, 64'h0);
            end else if (tx_wait) begin
                chk("beat_hold", tx_packet, exp_q[0]);
            end else begin
                chk("beat_data", tx_packet, exp_q.pop_front());
            end
        end else begin
            chk("idle_bus_zero", tx_packet, 64'h0);
        end
    end

    // Sends base packet 0x01.. at width code; optional stall and mid-packet width change.
    task automatic run_pkt(input logic [1:0] code, input int exp_high, input int stall_beat,
                           input int stall_len, input logic [1:0] code_mid, input int mid_beat);
        int high;
        int beat;
        int stalled;
        bit done;
        high = 0; beat = 0; stalled = 0; done = 0;
        iowidth   = code;
        packet_in = make_pkt(8'h01);
        access_in = 1'b1;
        push_beats(8'h01, int'(code));
        @(posedge clk); #1;
        access_in = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tx_wait = (beat == stall_beat) && (stalled < stall_len);
            if (beat == mid_beat) iowidth = code_mid;
            @(negedge clk);
            if (c == 0) chk("first_beat_latency", {63'h0, tx_access}, 64'h1);
            if (tx_access) begin
                high++;
                if (tx_wait) stalled++;
                else beat++;
                chk("wait_out_in_send", {63'h0, wait_out}, 64'h1);
            end else begin
                done = 1;
                chk("wait_out_in_gap", {63'h0, wait_out}, 64'h0);
            end
            @(posedge clk); #1;
        end
        tx_wait = 1'b0;
        iowidth = code;
        chk("packet_end_seen", {63'h0, done}, 64'h1);
        chk("access_high_cycles", 64'(high), 64'(exp_high));
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        nreset    = 1'b0;
        access_in = 1'b0;
        iowidth   = 2'd0;
        packet_in = '0;
        tx_wait   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_access", {63'h0, tx_access}, 64'h0);
        chk("reset_wait_out", {63'h0, wait_out}, 64'h0);
        chk("reset_tx_packet", tx_packet, 64'h0);
        nreset = 1'b1;
        @(posedge clk); #1;

        // tx_wait in IDLE has no effect
        tx_wait = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_wait_access", {63'h0, tx_access}, 64'h0);
        chk("idle_wait_waitout", {63'h0, wait_out}, 64'h0);
        tx_wait = 1'b0;

        run_pkt(2'd0, 13, -1, 0, 2'd0, -1);
        run_pkt(2'd3, 2, -1, 0, 2'd3, -1);
        run_pkt(2'd1, 7, -1, 0, 2'd3, 2);
        run_pkt(2'd0, 15, 3, 2, 2'd0, -1);

        // Back-to-back packets with access_in held high
        iowidth   = 2'd0;
        packet_in = make_pkt(8'h01);
        access_in = 1'b1;
        push_beats(8'h01, 0);
        push_beats(8'h11, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 28; c++) begin
            if (c == 1) packet_in = make_pkt(8'h11);
            if (c == 14) access_in = 1'b0;
            @(negedge clk);
            chk("b2b_access", {63'h0, tx_access}, {63'h0, (c != 13 && c != 27)});
            chk("b2b_wait_out", {63'h0, wait_out}, {63'h0, (c != 13 && c != 27)});
            @(posedge clk); #1;
        end
        chk("b2b_queue_drained", 64'(exp_q.size()), 64'h0);

        // Reset mid-packet at beat 5
        packet_in = make_pkt(8'h01);
        access_in = 1'b1;
        push_beats(8'h01, 0);
        @(posedge clk); #1;
        access_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_beat5", tx_packet, 64'h06);
        #2;
        nreset = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_access", {63'h0, tx_access}, 64'h0);
        chk("midreset_packet", tx_packet, 64'h0);
        chk("midreset_wait_out", {63'h0, wait_out}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        run_pkt(2'd0, 13, -1, 0, 2'd0, -1);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
